// File: rtl/ofdm_symbol_scheduler_pkg.sv
// Constants and read-state encoding shared by the OFDM transmitter blocks
// (symbol scheduler, IFFT and framer).
package ofdm_pkg;

  localparam int N_FFT  = 64;
  localparam int CP_LEN = 16;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ofdm_symbol_scheduler_if.sv
// Sample handshake and ping-pong RAM strobes between the symbol scheduler
// and its neighbours. The scheduler is the master side.
interface ofdm_symbol_scheduler_if #(
  parameter int ADDR_W = ofdm_pkg::ADDR_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              out_ready;
  logic              rd_en;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              out_valid;
  logic              cp_active;
  logic              sym_start;
  logic [7:0]        sym_count;
  logic              overflow;

  modport master (
    input  in_valid, out_ready,
    output in_ready, wr_en, wr_bank, wr_addr,
    output rd_en, rd_bank, rd_addr, out_valid, cp_active, sym_start,
    output sym_count, overflow
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, wr_en, wr_bank, wr_addr,
    input  rd_en, rd_bank, rd_addr, out_valid, cp_active, sym_start,
    input  sym_count, overflow
  );

endinterface

// File: rtl/ofdm_cp_addr_gen.sv
// Read sequencer: walks a full bank as cyclic prefix followed by body and
// reports completion so the bank-full tracker can release it.
module ofdm_cp_addr_gen
  import ofdm_pkg::*;
#(
  parameter int N_FFT  = ofdm_pkg::N_FFT,
  parameter int CP_LEN = ofdm_pkg::CP_LEN,
  parameter int ADDR_W = ofdm_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_ready_i,
  input  logic [1:0]        full_i,
  output logic              rd_en_o,
  output logic              rd_bank_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              out_valid_o,
  output logic              cp_active_o,
  output logic              sym_start_o,
  output logic              done_o
);

  localparam logic [1:0] S_IDLE = RD_IDLE;
  localparam logic [1:0] S_CP   = RD_CP;
  localparam logic [1:0] S_BODY = RD_BODY;

  localparam logic [ADDR_W-1:0] CP_START  = ADDR_W'(N_FFT - CP_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FFT - 1);

  logic [1:0]        state_q, state_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              out_valid_q, cp_active_q, sym_start_q;
  logic              rd_en;
  logic              at_last;
  logic              done;

  assign rd_en   = out_ready_i && (state_q != S_IDLE);
  assign at_last = (addr_q == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_i[bank_q]) begin
          state_d = S_CP;
          addr_d  = CP_START;
        end
      end
      S_CP: begin
        if (rd_en) begin
          addr_d = addr_q + ADDR_W'(1);
          if (at_last) state_d = S_BODY;
        end
      end
      S_BODY: begin
        if (rd_en) begin
          addr_d = addr_q + ADDR_W'(1);
          if (at_last) begin
            done   = 1'b1;
            bank_d = ~bank_q;
            // Chain straight into the other bank's prefix when it is ready,
            // so consecutive symbols leave no idle cycle on the output.
            if (full_i[~bank_q]) begin
              state_d = S_CP;
              addr_d  = CP_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bank_q      <= 1'b0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      cp_active_q <= 1'b0;
      sym_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      out_valid_q <= rd_en;
      cp_active_q <= rd_en && (state_q == S_CP);
      sym_start_q <= rd_en && (state_q == S_CP) && (addr_q == CP_START);
    end
  end

  assign rd_en_o     = rd_en;
  assign rd_bank_o   = bank_q;
  assign rd_addr_o   = addr_q;
  assign out_valid_o = out_valid_q;
  assign cp_active_o = cp_active_q;
  assign sym_start_o = sym_start_q;
  assign done_o      = done;

endmodule

// File: rtl/ofdm_symbol_scheduler.sv
// Ping-pong symbol scheduler: fills two RAM banks from the IFFT and plays
// each full bank out with its cyclic prefix prepended.
module ofdm_symbol_scheduler
  import ofdm_pkg::*;
#(
  parameter int N_FFT  = ofdm_pkg::N_FFT,
  parameter int CP_LEN = ofdm_pkg::CP_LEN,
  parameter int ADDR_W = ofdm_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  ofdm_symbol_scheduler_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FFT - 1);

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              overflow_q;
  logic [7:0]        sym_count_q;

  logic              in_ready;
  logic              wr_en;
  logic              wr_last;
  logic              rd_bank;
  logic              rd_done;

  assign in_ready = ~full_q[wr_bank_q];
  assign wr_en    = bus.in_valid & in_ready;
  assign wr_last  = wr_en && (wr_addr_q == LAST_ADDR);

  // Writer and reader never touch the same bank's flag in one cycle.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank]   = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      overflow_q  <= 1'b0;
      sym_count_q <= 8'd0;
    end else begin
      full_q <= full_d;
      if (wr_en) wr_addr_q <= wr_addr_q + ADDR_W'(1);
      if (wr_last) wr_bank_q <= ~wr_bank_q;
      if (bus.in_valid && !in_ready) overflow_q <= 1'b1;
      if (rd_done) sym_count_q <= sym_count_q + 8'd1;
    end
  end

  ofdm_cp_addr_gen #(
    .N_FFT  (N_FFT),
    .CP_LEN (CP_LEN),
    .ADDR_W (ADDR_W)
  ) u_cp_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .out_ready_i (bus.out_ready),
    .full_i      (full_q),
    .rd_en_o     (bus.rd_en),
    .rd_bank_o   (rd_bank),
    .rd_addr_o   (bus.rd_addr),
    .out_valid_o (bus.out_valid),
    .cp_active_o (bus.cp_active),
    .sym_start_o (bus.sym_start),
    .done_o      (rd_done)
  );

  assign bus.in_ready  = in_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_bank   = wr_bank_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.rd_bank   = rd_bank;
  assign bus.sym_count = sym_count_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Bench for ofdm_symbol_scheduler: three builds (CP 16, 1, 63) run side by
// side against a symbol-stream reference model.
module tb_ofdm_symbol_scheduler;
  import ofdm_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid_a  [NI];
  logic              out_ready_a [NI];
  logic              in_ready_a  [NI];
  logic              overflow_a  [NI];
  logic [7:0]        symc_a      [NI];
  logic [ADDR_W-1:0] wra_a       [NI];
  int                ov_cnt_a    [NI];
  int                first_a     [NI];
  int                last_a      [NI];
  int                lastwr_a    [NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cp_of(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 1 : 63);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int CPL = (gi == 0) ? 16 : ((gi == 1) ? 1 : 63);

    ofdm_symbol_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    assign bus.in_valid  = in_valid_a[gi];
    assign bus.out_ready = out_ready_a[gi];
    assign in_ready_a[gi] = bus.in_ready;
    assign overflow_a[gi] = bus.overflow;
    assign symc_a[gi]     = bus.sym_count;
    assign wra_a[gi]      = bus.wr_addr;

    ofdm_symbol_scheduler #(
      .N_FFT  (N_FFT),
      .CP_LEN (CPL),
      .ADDR_W (ADDR_W)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
    );

    // Reference model: a queue of completed symbols (cycle each finished
    // writing), a position in the symbol being played, and write counters.
    int cyc = 0, wsym = 0, wcnt = 0, rsym = 0, rpos = 0, prev_end = -100;
    int ov_cnt = 0, first_ov = -1, last_ov = -1, last_wr = -1;
    int wdone[$];
    bit ovf = 0, prev_rd = 0, prev_cp = 0, prev_ss = 0;
    bit rdy_e, wr_e, rd_e, act;
    int p;

    always @(negedge clk) begin
      cyc++;
      if (reset) begin
        wsym = 0; wcnt = 0; rsym = 0; rpos = 0; prev_end = -100;
        ov_cnt = 0; first_ov = -1; last_ov = -1; last_wr = -1;
        wdone.delete();
        ovf = 0; prev_rd = 0; prev_cp = 0; prev_ss = 0;
      end else begin
        rdy_e = (wdone.size() < 2);
        wr_e  = in_valid_a[gi] && rdy_e;
        check_eq($sformatf("%0d.in_ready", gi), 32'(bus.in_ready), 32'(rdy_e));
        check_eq($sformatf("%0d.wr_en", gi), 32'(bus.wr_en), 32'(wr_e));
        check_eq($sformatf("%0d.wr_bank", gi), 32'(bus.wr_bank), 32'(wsym % 2));
        check_eq($sformatf("%0d.wr_addr", gi), 32'(bus.wr_addr), 32'(wcnt));
        check_eq($sformatf("%0d.overflow", gi), 32'(bus.overflow), 32'(ovf));
        check_eq($sformatf("%0d.sym_count", gi), 32'(bus.sym_count), 32'(rsym % 256));
        check_eq($sformatf("%0d.out_valid", gi), 32'(bus.out_valid), 32'(prev_rd));
        check_eq($sformatf("%0d.cp_active", gi), 32'(bus.cp_active), 32'(prev_cp));
        check_eq($sformatf("%0d.sym_start", gi), 32'(bus.sym_start), 32'(prev_ss));

        // A symbol may start two cycles after its last write, and no
        // earlier than the cycle after the previous symbol's last read.
        act  = (rpos > 0) ||
               (wdone.size() > 0 && cyc >= wdone[0] + 2 && cyc >= prev_end + 1);
        rd_e = out_ready_a[gi] && act;
        check_eq($sformatf("%0d.rd_en", gi), 32'(bus.rd_en), 32'(rd_e));
        p = (rpos < CPL) ? (N_FFT - CPL + rpos) : (rpos - CPL);
        if (rd_e) begin
          check_eq($sformatf("%0d.rd_bank", gi), 32'(bus.rd_bank), 32'(rsym % 2));
          check_eq($sformatf("%0d.rd_addr", gi), 32'(bus.rd_addr), 32'(p));
        end

        if (bus.out_valid) begin
          ov_cnt++;
          if (first_ov < 0) first_ov = cyc;
          last_ov = cyc;
        end
        prev_rd = rd_e;
        prev_cp = rd_e && (rpos < CPL);
        prev_ss = rd_e && (rpos == 0);
        if (rd_e) begin
          rpos++;
          if (rpos == N_FFT + CPL) begin
            rpos = 0;
            rsym++;
            void'(wdone.pop_front());
            prev_end = cyc;
          end
        end
        if (in_valid_a[gi] && !rdy_e) ovf = 1;
        if (wr_e) begin
          last_wr = cyc;
          wcnt++;
          if (wcnt == N_FFT) begin
            wcnt = 0;
            wsym++;
            wdone.push_back(cyc);
          end
        end
      end
    end

    assign ov_cnt_a[gi] = ov_cnt;
    assign first_a[gi]  = first_ov;
    assign last_a[gi]   = last_ov;
    assign lastwr_a[gi] = last_wr;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < NI; i++) in_valid_a[i] = 1'b0;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    for (int i = 0; i < NI; i++) out_ready_a[i] = v;
  endtask

  // Offer samples only while each build is ready, until 'total' accepted.
  task automatic write_polite(input int total, input int max_cyc, input string tag);
    int acc[NI];
    int c;
    bit fin;
    c = 0;
    fin = 0;
    for (int i = 0; i < NI; i++) acc[i] = 0;
    while (c < max_cyc) begin
      fin = 1;
      for (int i = 0; i < NI; i++) begin
        if (acc[i] < total) begin
          fin = 0;
          if (in_ready_a[i]) begin
            in_valid_a[i] = 1'b1;
            acc[i]++;
          end else begin
            in_valid_a[i] = 1'b0;
          end
        end else begin
          in_valid_a[i] = 1'b0;
        end
      end
      if (fin) break;
      tick(1);
      c++;
    end
    for (int i = 0; i < NI; i++) in_valid_a[i] = 1'b0;
    check_eq({tag, ".write_done"}, 32'(fin), 32'd1);
  endtask

  initial begin
    int c;
    bit reached;
    for (int i = 0; i < NI; i++) begin
      in_valid_a[i] = 1'b0;
      out_ready_a[i] = 1'b1;
    end
    do_reset(3);

    // One symbol, output always ready.
    write_polite(64, 200, "A");
    tick(150);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("A%0d.len", i), 32'(ov_cnt_a[i]), 32'(N_FFT + cp_of(i)));
      check_eq($sformatf("A%0d.symc", i), 32'(symc_a[i]), 32'd1);
      check_eq($sformatf("A%0d.latency", i), 32'(first_a[i] - lastwr_a[i]), 32'd3);
    end

    // Four symbols streamed back to back.
    do_reset(2);
    write_polite(256, 2000, "B");
    tick(500);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("B%0d.len", i), 32'(ov_cnt_a[i]), 32'(4 * (N_FFT + cp_of(i))));
      check_eq($sformatf("B%0d.contig", i), 32'(last_a[i] - first_a[i] + 1), 32'(ov_cnt_a[i]));
      check_eq($sformatf("B%0d.symc", i), 32'(symc_a[i]), 32'd4);
      check_eq($sformatf("B%0d.ovf", i), 32'(overflow_a[i]), 32'd0);
    end

    // Both banks full with the output stalled, then one dropped sample.
    do_reset(2);
    set_ready(1'b0);
    write_polite(128, 400, "C");
    tick(3);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("C%0d.in_ready", i), 32'(in_ready_a[i]), 32'd0);
      in_valid_a[i] = 1'b1;
    end
    tick(1);
    for (int i = 0; i < NI; i++) in_valid_a[i] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("C%0d.ovf", i), 32'(overflow_a[i]), 32'd1);
      check_eq($sformatf("C%0d.wr_addr", i), 32'(wra_a[i]), 32'd0);
    end
    set_ready(1'b1);
    tick(600);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("C%0d.symc", i), 32'(symc_a[i]), 32'd2);
      check_eq($sformatf("C%0d.ovf_sticky", i), 32'(overflow_a[i]), 32'd1);
    end

    // Output ready toggling every cycle during a symbol.
    do_reset(2);
    write_polite(64, 200, "D");
    for (c = 0; c < 400; c++) begin
      set_ready(c[0] == 1'b0);
      tick(1);
    end
    set_ready(1'b1);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("D%0d.len", i), 32'(ov_cnt_a[i]), 32'(N_FFT + cp_of(i)));
      check_eq($sformatf("D%0d.symc", i), 32'(symc_a[i]), 32'd1);
    end

    // Reset in the middle of a symbol body.
    do_reset(2);
    write_polite(64, 200, "E");
    reached = 0;
    for (c = 0; c < 200; c++) begin
      if (ov_cnt_a[0] >= cp_of(0) + 10) begin
        reached = 1;
        break;
      end
      tick(1);
    end
    check_eq("E.reach_body", 32'(reached), 32'd1);
    do_reset(1);
    tick(100);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("E%0d.no_out", i), 32'(ov_cnt_a[i]), 32'd0);
      check_eq($sformatf("E%0d.in_ready", i), 32'(in_ready_a[i]), 32'd1);
      check_eq($sformatf("E%0d.symc", i), 32'(symc_a[i]), 32'd0);
    end
    write_polite(64, 200, "E2");
    tick(150);
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("E%0d.fresh_len", i), 32'(ov_cnt_a[i]), 32'(N_FFT + cp_of(i)));

    // Random traffic with occasional resets.
    do_reset(2);
    for (c = 0; c < 4000; c++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid_a[i]  = ($urandom_range(0, 99) < 55);
        out_ready_a[i] = ($urandom_range(0, 99) < 70);
      end
      reset = ($urandom_range(0, 1499) == 0);
      tick(1);
    end
    reset = 1'b0;
    for (int i = 0; i < NI; i++) in_valid_a[i] = 1'b0;
    set_ready(1'b1);
    tick(400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
